// File: rtl/mcu_wb_arb.sv
// Purpose : arbitrates the single register-file write port between the EX/MEM
//           pipe result and LSU load returns. LSU returns are buffered in a small
//           FIFO, and a wait counter keeps the pipe from being starved.
// Latency : 1 cycle from grant to wb_valid/wb_rd/wb_data (registered).
// Backpr. : pipe is held via pipe_ready; the LSU cannot be stalled, so lsu_full
//           asks it to stop issuing, and a beat arriving on a full FIFO is dropped
//           and latched in ovf_err.
// Ports   : clk, rst_n (sync, active-low)
//           pipe_valid/pipe_rd/pipe_data -> pipe_ready
//           lsu_valid/lsu_rd/lsu_data    -> lsu_full, lsu_count, ovf_err
//           wb_stall -> wb_valid/wb_rd/wb_data

// Purpose : generic circular FIFO with a push that is accepted only when there
//           is room, or when the head is popped in the same cycle.
// Latency : an entry can be popped the cycle after it is pushed; head is combinational.
// Backpr. : the FIFO ignores a push when full with no pop; the caller sees full.
// Ports   : clk, rst_n, push/wr_dat, pop, head, cnt, full
module mcu_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wr_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [2:0]   cnt,
  output logic         full
);
  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam logic [2:0] CNT_FULL = 3'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap at DEPTH explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    nxt = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CNT_FULL);
  assign do_pop  = pop && (cnt != 3'd0);
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= 3'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= nxt(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= cnt - 3'd1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module mcu_wb_arb #(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  output logic        pipe_ready,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic        wb_stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        lsu_full,
  output logic [2:0]  lsu_count,
  output logic        ovf_err
);
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  wb_ent_t    lsu_ent;
  wb_ent_t    head_ent;
  wb_ent_t    win_ent;
  logic [2:0] count;
  logic       fifo_full;
  logic [3:0] wait_cnt;

  logic lsu_ok;
  logic pipe_req;
  logic pipe_nop;
  logic lsu_cand;
  logic pipe_force;
  logic gnt_pipe;
  logic gnt_lsu;
  logic pop;
  logic bypass;
  logic push;
  logic drop;

  assign lsu_ent = '{rd: lsu_rd, data: lsu_data};

  // Writes to x0 never use the port: LSU ones are discarded, pipe ones are
  // acknowledged immediately.
  assign lsu_ok   = lsu_valid && (lsu_rd != 5'd0);
  assign pipe_req = pipe_valid && (pipe_rd != 5'd0);
  assign pipe_nop = pipe_valid && (pipe_rd == 5'd0);

  // Buffered entries always come before a fresh beat, so bypass only happens
  // with an empty FIFO and beat order is kept.
  assign lsu_cand   = (count != 3'd0) || lsu_ok;
  // A long-waiting pipe may jump ahead only while the FIFO still has room,
  // otherwise the LSU would be forced to drop its next return.
  assign pipe_force = pipe_req && (wait_cnt >= WAIT_LIM) && !fifo_full;

  always_comb begin
    gnt_pipe = 1'b0;
    gnt_lsu  = 1'b0;
    if (rst_n && !wb_stall) begin
      if (pipe_force) begin
        gnt_pipe = 1'b1;
      end else if (lsu_cand) begin
        gnt_lsu = 1'b1;
      end else if (pipe_req) begin
        gnt_pipe = 1'b1;
      end
    end
  end

  assign pop    = gnt_lsu && (count != 3'd0);
  assign bypass = gnt_lsu && (count == 3'd0);
  assign push   = rst_n && lsu_ok && !bypass;
  assign drop   = push && fifo_full && !pop;

  always_comb begin
    win_ent = lsu_ent;
    if (gnt_pipe) begin
      win_ent = '{rd: pipe_rd, data: pipe_data};
    end else if (count != 3'd0) begin
      win_ent = head_ent;
    end
  end

  mcu_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(wb_ent_t))
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .wr_dat (lsu_ent),
    .pop    (pop),
    .head   (head_ent),
    .cnt    (count),
    .full   (fifo_full)
  );

  assign pipe_ready = rst_n && (pipe_nop || gnt_pipe);
  assign lsu_full   = rst_n && fifo_full;
  assign lsu_count  = count;

  // Counts consecutive cycles a real pipe write is left waiting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= 4'd0;
    end else if (pipe_req && !gnt_pipe) begin
      if (wait_cnt != 4'd15) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end else begin
      wait_cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
    end else if (drop) begin
      ovf_err <= 1'b1;
    end
  end

  // wb_rd/wb_data hold their last value when nothing is granted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= 32'd0;
    end else begin
      wb_valid <= gnt_pipe || gnt_lsu;
      if (gnt_pipe || gnt_lsu) begin
        wb_rd   <= win_ent.rd;
        wb_data <= win_ent.data;
      end
    end
  end
endmodule

// File: tb/tb_mcu_wb_arb.sv
// Purpose : directed, table-driven check of mcu_wb_arb (FIFO_DEPTH=2, MAX_WAIT=4).
// Latency : each vector is one clock; pipe_ready/lsu_full checked before the edge,
//           registered outputs checked just after it.
// Ports   : drives every DUT input, observes every DUT output.
module tb_mcu_wb_arb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        wb_stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lsu_full;
  logic [2:0]  lsu_count;
  logic        ovf_err;

  always #5 clk = ~clk;

  mcu_wb_arb #(.FIFO_DEPTH(2), .MAX_WAIT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_valid (pipe_valid),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .pipe_ready (pipe_ready),
    .lsu_valid  (lsu_valid),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .wb_stall   (wb_stall),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .lsu_full   (lsu_full),
    .lsu_count  (lsu_count),
    .ovf_err    (ovf_err)
  );

  typedef struct {
    logic        r;
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        st;
    logic        er;
    logic        ev;
    logic [4:0]  erd;
    logic [31:0] ed;
    logic [2:0]  ec;
    logic        ef;
    logic        eo;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  logic last_full = 1'b0;
  vec_t tbl [25];

  function automatic vec_t mk(
    input logic r, input logic pv, input logic [4:0] prd, input logic [31:0] pd,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ld, input logic st,
    input logic er, input logic ev, input logic [4:0] erd, input logic [31:0] ed,
    input logic [2:0] ec, input logic ef, input logic eo);
    vec_t v;
    v.r = r; v.pv = pv; v.prd = prd; v.pd = pd;
    v.lv = lv; v.lrd = lrd; v.ld = ld; v.st = st;
    v.er = er; v.ev = ev; v.erd = erd; v.ed = ed;
    v.ec = ec; v.ef = ef; v.eo = eo;
    return v;
  endfunction

  function automatic logic [31:0] rep(input int x);
    return 32'(x) * 32'h01010101;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    rst_n      = v.r;
    pipe_valid = v.pv;
    pipe_rd    = v.prd;
    pipe_data  = v.pd;
    lsu_valid  = v.lv;
    lsu_rd     = v.lrd;
    lsu_data   = v.ld;
    wb_stall   = v.st;
    #1;
    chk({tag, " pipe_ready"}, 32'(pipe_ready), 32'(v.er));
    chk({tag, " lsu_full_pre"}, 32'(lsu_full), v.r ? 32'(last_full) : 32'd0);
    @(posedge clk);
    #1;
    chk({tag, " wb_valid"}, 32'(wb_valid), 32'(v.ev));
    chk({tag, " wb_rd"}, 32'(wb_rd), 32'(v.erd));
    chk({tag, " wb_data"}, wb_data, v.ed);
    chk({tag, " lsu_count"}, 32'(lsu_count), 32'(v.ec));
    chk({tag, " lsu_full"}, 32'(lsu_full), 32'(v.ef));
    chk({tag, " ovf_err"}, 32'(ovf_err), 32'(v.eo));
    last_full = v.ef;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0; wb_stall = 1'b0;

    //              r pv prd pd            lv lrd ld            st | er ev erd ed            ec ef eo
    // reset, idle, single LSU bypass, discarded rd=0 beat
    tbl[0]  = mk(0, 0, 0,  32'h0,         0, 0,  32'h0,         0,  0, 0, 0,  32'h0,         0, 0, 0);
    tbl[1]  = mk(1, 0, 0,  32'h0,         0, 0,  32'h0,         0,  0, 0, 0,  32'h0,         0, 0, 0);
    tbl[2]  = mk(1, 0, 0,  32'h0,         1, 5,  32'hA5A5A5A5,  0,  0, 1, 5,  32'hA5A5A5A5,  0, 0, 0);
    tbl[3]  = mk(1, 0, 0,  32'h0,         1, 0,  32'hDEADBEEF,  0,  0, 0, 5,  32'hA5A5A5A5,  0, 0, 0);
    // pipe vs LSU in the same cycle: LSU first, pipe next
    tbl[4]  = mk(1, 1, 3,  32'h33333333,  1, 7,  32'h77777777,  0,  0, 1, 7,  32'h77777777,  0, 0, 0);
    tbl[5]  = mk(1, 1, 3,  32'h33333333,  0, 0,  32'h0,         0,  1, 1, 3,  32'h33333333,  0, 0, 0);
    tbl[6]  = mk(1, 0, 0,  32'h0,         0, 0,  32'h0,         0,  0, 0, 3,  32'h33333333,  0, 0, 0);
    // fill under stall, then pop+push on a full FIFO, drain in order
    tbl[7]  = mk(1, 0, 0,  32'h0,         1, 1,  32'h11111111,  1,  0, 0, 3,  32'h33333333,  1, 0, 0);
    tbl[8]  = mk(1, 0, 0,  32'h0,         1, 2,  32'h22222222,  1,  0, 0, 3,  32'h33333333,  2, 1, 0);
    tbl[9]  = mk(1, 0, 0,  32'h0,         1, 6,  32'h66666666,  0,  0, 1, 1,  32'h11111111,  2, 1, 0);
    tbl[10] = mk(1, 0, 0,  32'h0,         0, 0,  32'h0,         0,  0, 1, 2,  32'h22222222,  1, 0, 0);
    tbl[11] = mk(1, 0, 0,  32'h0,         0, 0,  32'h0,         0,  0, 1, 6,  32'h66666666,  0, 0, 0);
    tbl[12] = mk(1, 0, 0,  32'h0,         0, 0,  32'h0,         0,  0, 0, 6,  32'h66666666,  0, 0, 0);
    // three beats under stall: third dropped, ovf_err sticky
    tbl[13] = mk(1, 0, 0,  32'h0,         1, 1,  32'h01010101,  1,  0, 0, 6,  32'h66666666,  1, 0, 0);
    tbl[14] = mk(1, 0, 0,  32'h0,         1, 2,  32'h02020202,  1,  0, 0, 6,  32'h66666666,  2, 1, 0);
    tbl[15] = mk(1, 0, 0,  32'h0,         1, 4,  32'h04040404,  1,  0, 0, 6,  32'h66666666,  2, 1, 1);
    // pipe rd=0 acked despite stall; full FIFO beats the pipe
    tbl[16] = mk(1, 1, 0,  32'h00000BAD,  0, 0,  32'h0,         1,  1, 0, 6,  32'h66666666,  2, 1, 1);
    tbl[17] = mk(1, 1, 8,  32'h88888888,  0, 0,  32'h0,         0,  0, 1, 1,  32'h01010101,  1, 0, 1);
    tbl[18] = mk(1, 1, 8,  32'h88888888,  0, 0,  32'h0,         0,  0, 1, 2,  32'h02020202,  0, 0, 1);
    tbl[19] = mk(1, 1, 8,  32'h88888888,  0, 0,  32'h0,         0,  1, 1, 8,  32'h88888888,  0, 0, 1);
    // reset with a full FIFO: contents lost, nothing written
    tbl[20] = mk(1, 0, 0,  32'h0,         1, 10, 32'hA0A0A0A0,  1,  0, 0, 8,  32'h88888888,  1, 0, 1);
    tbl[21] = mk(1, 0, 0,  32'h0,         1, 11, 32'hB0B0B0B0,  1,  0, 0, 8,  32'h88888888,  2, 1, 1);
    tbl[22] = mk(0, 1, 13, 32'hD0D0D0D0,  1, 12, 32'hC0C0C0C0,  0,  0, 0, 0,  32'h0,         0, 0, 0);
    tbl[23] = mk(1, 1, 0,  32'h0,         0, 0,  32'h0,         0,  1, 0, 0,  32'h0,         0, 0, 0);
    tbl[24] = mk(1, 0, 0,  32'h0,         1, 14, 32'hE0E0E0E0,  0,  0, 1, 14, 32'hE0E0E0E0,  0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      run_vec(tbl[i], $sformatf("v%0d", i));
    end

    // Pipe held at rd=9 against a steady LSU stream: four LSU bypasses,
    // then the pipe is forced through and the concurrent beat is buffered.
    for (int i = 0; i < 4; i++) begin
      run_vec(mk(1, 1, 9, 32'h99999999, 1, 5'(16 + i), rep(16 + i), 0,
                 0, 1, 5'(16 + i), rep(16 + i), 0, 0, 0), $sformatf("starve%0d", i));
    end
    run_vec(mk(1, 1, 9, 32'h99999999, 1, 20, rep(20), 0,
               1, 1, 9, 32'h99999999, 1, 0, 0), "starve_force");
    run_vec(mk(1, 0, 0, 32'h0, 1, 21, rep(21), 0,
               0, 1, 20, rep(20), 1, 0, 0), "starve_pp");
    run_vec(mk(1, 0, 0, 32'h0, 0, 0, 32'h0, 0,
               0, 1, 21, rep(21), 0, 0, 0), "starve_drain");

    // Pipe waits past MAX_WAIT while the FIFO is full: the LSU still wins
    // once, then the pipe is forced ahead of the remaining entry.
    run_vec(mk(1, 1, 9, 32'h99999999, 1, 24, rep(24), 1,
               0, 0, 21, rep(21), 1, 0, 0), "full_b0");
    run_vec(mk(1, 1, 9, 32'h99999999, 1, 25, rep(25), 1,
               0, 0, 21, rep(21), 2, 1, 0), "full_b1");
    for (int i = 2; i < 5; i++) begin
      run_vec(mk(1, 1, 9, 32'h99999999, 0, 0, 32'h0, 1,
                 0, 0, 21, rep(21), 2, 1, 0), $sformatf("full_b%0d", i));
    end
    run_vec(mk(1, 1, 9, 32'h99999999, 0, 0, 32'h0, 0,
               0, 1, 24, rep(24), 1, 0, 0), "full_lsu_wins");
    run_vec(mk(1, 1, 9, 32'h99999999, 0, 0, 32'h0, 0,
               1, 1, 9, 32'h99999999, 1, 0, 0), "full_pipe_forced");
    run_vec(mk(1, 0, 0, 32'h0, 0, 0, 32'h0, 0,
               0, 1, 25, rep(25), 0, 0, 0), "full_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
